norm_share_arbiter: RTL and testbench
=====================================

Name: norm_share_arbiter

Overview:
- Shares one combinational mantissa normalizer (leading-sign shift, outputs shifted mantissa plus shift count) between NUM_REQ requesters in the custom float datapath (MANTISSA-bit two's-complement mantissa, EXPONENT-bit unsigned exponent).
- Arbitrates round-robin and drives the shared unit from a registered operand.
- Subtracts the returned shift count from the requester's exponent, handling underflow.
- Returns a tagged result over a valid/ready interface with full backpressure.

Parameters:
- NUM_REQ, 4, number of requesters.
- MANTISSA, 11, mantissa width (two's complement).
- EXPONENT, 5, exponent width (unsigned).
- ID_W, 2, requester tag width; equals clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_mantissa  in  NUM_REQ*MANTISSA  packed mantissas; requester i at [i*MANTISSA +: MANTISSA].
- req_exponent  in  NUM_REQ*EXPONENT  packed exponents, same packing.
- norm_in_mantissa  out  MANTISSA  operand to the shared normalizer.
- norm_out_mantissa  in  MANTISSA  normalized mantissa from the shared unit (combinational from norm_in_mantissa).
- norm_en_out  in  EXPONENT  shift count from the shared unit (0..MANTISSA-2).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_mantissa  out  MANTISSA  normalized mantissa.
- out_exponent  out  EXPONENT  adjusted exponent.
- out_id  out  ID_W  index of the originating requester.
- out_underflow  out  1  exponent underflow flag.

Behaviour:
- Two register stages:
  - S1 holds the operand: s1_valid, mantissa, exponent, id.
  - S2 is the output register: out_*.
- norm_in_mantissa = S1 mantissa; it is 0 when S1 is empty.
- Arbitration:
  - rr_ptr resets to 0.
  - Grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- Acceptance:
  - s1_load = !s1_valid || s2_load.
  - req_ready[g] = s1_load when any req_valid is set; all other req_ready bits are 0.
  - req_ready is combinational from req_valid and state.
  - On a transfer (req_valid[g] && req_ready[g]), S1 captures requester g's operand and rr_ptr <= (g+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
- Drain logic:
  - s2_load = s1_valid && (!out_valid || out_ready). When true, S2 captures the normalizer result and S1 clears unless reloaded the same cycle.
  - out_valid && out_ready && !s2_load clears out_valid.
  - While out_valid && !out_ready, all out_* hold stable.
- Exponent arithmetic, computed at S2 load:
  - If norm_en_out <= S1 exponent: out_exponent = exponent - norm_en_out, out_mantissa = norm_out_mantissa, out_underflow = 0.
  - Else (underflow): out_exponent = 0, out_mantissa = 0, out_underflow = 1.
  - Mantissa all-zero or all-ones: the shared unit returns a shift of 0; the operand passes through unchanged with the exponent unchanged.
- Latency: a transfer at edge T makes out_valid high after edge T+1 (2 cycles).
- Throughput: 1 result per cycle while out_ready = 1.
- Results leave in acceptance order; none are dropped or duplicated.
- Reset:
  - rst high at any edge clears s1_valid, out_valid, rr_ptr, out_mantissa, out_exponent, out_id and out_underflow to 0.
  - In-flight operands are discarded.
  - req_ready is 0 during the reset cycle.
- Simultaneous events:
  - S2 drain and S1 reload in the same cycle are legal and sustain full rate.
  - A requester that deasserts req_valid before a grant loses nothing; the grant moves to the next valid requester in that cycle.

Test Plan:
- Req 0 sends mantissa 11'b00001000000, exp 10; out_ready=1 → 2 cycles later: out_mantissa 11'b01000000000, out_exponent 7, out_id 0, out_underflow 0.
- Req 2 sends mantissa 11'b11110000000, exp 3 → out_mantissa 11'b10000000111, out_exponent 0, out_id 2, out_underflow 0.
- Req 1 sends mantissa 11'b00000000001, exp 5 (shift 9 > 5) → out_mantissa 0, out_exponent 0, out_underflow 1; mantissa 0, exp 4 → mantissa 0, exp 4, out_underflow 0.
- All 4 requesters hold req_valid for 8 cycles; out_ready=1 → out_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles; exactly one req_ready high per cycle.
- Stream from req 3; out_ready low for 3 cycles → out_* stable for those cycles, req_ready[3] low once S1 fills; after release, every operand appears once, in order.
- Reset asserted with S1 and S2 both valid → out_valid 0 next cycle; rr_ptr restarts at 0; first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/norm_share_arbiter.sv
// Round-robin arbiter sharing one combinational mantissa normalizer between NUM_REQ requesters.
// Operand register (S1) drives the normalizer; output register (S2) applies the exponent adjust.
module norm_share_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MANTISSA = 11,
    parameter int unsigned EXPONENT = 5,
    parameter int unsigned ID_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*MANTISSA-1:0]  req_mantissa,
    input  logic [NUM_REQ*EXPONENT-1:0]  req_exponent,
    output logic [MANTISSA-1:0]          norm_in_mantissa,
    input  logic [MANTISSA-1:0]          norm_out_mantissa,
    input  logic [EXPONENT-1:0]          norm_en_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [MANTISSA-1:0]          out_mantissa,
    output logic [EXPONENT-1:0]          out_exponent,
    output logic [ID_W-1:0]              out_id,
    output logic                         out_underflow
);

    logic                s1_valid_q, s1_valid_d;
    logic [MANTISSA-1:0] s1_mant_q, s1_mant_d;
    logic [EXPONENT-1:0] s1_exp_q, s1_exp_d;
    logic [ID_W-1:0]     s1_id_q, s1_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                out_valid_q, out_valid_d;
    logic [MANTISSA-1:0] out_mant_q, out_mant_d;
    logic [EXPONENT-1:0] out_exp_q, out_exp_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic                out_uf_q, out_uf_d;

    logic            any_valid;
    logic            found;
    logic [ID_W-1:0] grant;
    logic            s1_load;
    logic            s2_load;
    logic            accept;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        any_valid = |req_valid;
        found     = 1'b0;
        grant     = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(32'(rr_ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                grant = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        s2_load = s1_valid_q && (!out_valid_q || out_ready);
        s1_load = !s1_valid_q || s2_load;
        accept  = any_valid && s1_load && !rst;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant == ID_W'(i));
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_exp_d   = s1_exp_q;
        s1_id_d    = s1_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_mant_d  = req_mantissa[32'(grant)*MANTISSA +: MANTISSA];
            s1_exp_d   = req_exponent[32'(grant)*EXPONENT +: EXPONENT];
            s1_id_d    = grant;
            rr_ptr_d   = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // Shift counts larger than the exponent flush the result to zero and flag underflow.
    always_comb begin
        out_valid_d = out_valid_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_id_d    = out_id_q;
        out_uf_d    = out_uf_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            out_id_d    = s1_id_q;
            if (norm_en_out <= s1_exp_q) begin
                out_mant_d = norm_out_mantissa;
                out_exp_d  = s1_exp_q - norm_en_out;
                out_uf_d   = 1'b0;
            end else begin
                out_mant_d = '0;
                out_exp_d  = '0;
                out_uf_d   = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mant_q   <= '0;
            s1_exp_q    <= '0;
            s1_id_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_id_q    <= '0;
            out_uf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mant_q   <= s1_mant_d;
            s1_exp_q    <= s1_exp_d;
            s1_id_q     <= s1_id_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_id_q    <= out_id_d;
            out_uf_q    <= out_uf_d;
        end
    end

    assign norm_in_mantissa = s1_valid_q ? s1_mant_q : '0;
    assign out_valid        = out_valid_q;
    assign out_mantissa     = out_mant_q;
    assign out_exponent     = out_exp_q;
    assign out_id           = out_id_q;
    assign out_underflow    = out_uf_q;

endmodule

// File: tb/tb_norm_share_arbiter.sv
// Bench for norm_share_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model; also provides the shared normalizer.
module tb_norm_share_arbiter;

    localparam int N  = 4;
    localparam int M  = 11;
    localparam int E  = 5;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*M-1:0] req_mantissa;
    logic [N*E-1:0] req_exponent;
    logic [M-1:0]   norm_in_mantissa;
    logic [M-1:0]   norm_out_mantissa;
    logic [E-1:0]   norm_en_out;
    logic           out_valid;
    logic           out_ready;
    logic [M-1:0]   out_mantissa;
    logic [E-1:0]   out_exponent;
    logic [IW-1:0]  out_id;
    logic           out_underflow;

    logic [M-1:0] mant [N];
    logic [E-1:0] expo [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_mantissa[i*M +: M] = mant[i];
            req_exponent[i*E +: E] = expo[i];
        end
    end

    // Redundant sign bits of the mantissa; zero for all-zero / all-ones.
    function automatic int ref_shift(logic [M-1:0] m);
        int s = 0;
        bit run = 1'b1;
        if (m == '0 || m == {M{1'b1}}) return 0;
        for (int i = M - 2; i >= 0; i--) begin
            if (run && m[i] == m[M-1]) s++;
            else run = 1'b0;
        end
        return s;
    endfunction

    function automatic logic [M-1:0] ref_norm(logic [M-1:0] m, int s);
        logic [M-1:0] r;
        r = m << s;
        if (m[M-1]) r = r | ~({M{1'b1}} << s);
        return r;
    endfunction

    assign norm_en_out       = E'(ref_shift(norm_in_mantissa));
    assign norm_out_mantissa = ref_norm(norm_in_mantissa, ref_shift(norm_in_mantissa));

    norm_share_arbiter #(
        .NUM_REQ (N),
        .MANTISSA(M),
        .EXPONENT(E),
        .ID_W    (IW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_mantissa     (req_mantissa),
        .req_exponent     (req_exponent),
        .norm_in_mantissa (norm_in_mantissa),
        .norm_out_mantissa(norm_out_mantissa),
        .norm_en_out      (norm_en_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_mantissa     (out_mantissa),
        .out_exponent     (out_exponent),
        .out_id           (out_id),
        .out_underflow    (out_underflow)
    );

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input int i, input logic [M-1:0] m, input logic [E-1:0] e);
        mant[i]   = m;
        expo[i]   = e;
        req_valid = 4'b0001 << i;
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_mantissa, out_exponent, out_id, out_underflow, norm_in_mantissa} !== '0)
        begin
            failures++;
            $display("FAIL reset_state: got v=%b m=%h e=%h id=%h uf=%b nin=%h expected all 0",
                     out_valid, out_mantissa, out_exponent, out_id, out_underflow,
                     norm_in_mantissa);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        send(0, 11'b00001000000, 5'd10);
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_mantissa, out_exponent, out_id, out_underflow} !==
            {1'b1, 11'b01000000000, 5'd7, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL norm_pos: got v=%b m=%b e=%0d id=%0d uf=%b expected 1 01000000000 7 0 0",
                     out_valid, out_mantissa, out_exponent, out_id, out_underflow);
        end
        send(2, 11'b11110000000, 5'd3);
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_mantissa, out_exponent, out_id, out_underflow} !==
            {1'b1, 11'b10000000111, 5'd0, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL norm_neg: got v=%b m=%b e=%0d id=%0d uf=%b expected 1 10000000111 0 2 0",
                     out_valid, out_mantissa, out_exponent, out_id, out_underflow);
        end
        send(1, 11'b00000000001, 5'd5);
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_mantissa, out_exponent, out_id, out_underflow} !==
            {1'b1, 11'd0, 5'd0, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL underflow: got v=%b m=%b e=%0d id=%0d uf=%b expected 1 0 0 1 1",
                     out_valid, out_mantissa, out_exponent, out_id, out_underflow);
        end
        send(1, 11'd0, 5'd4);
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_mantissa, out_exponent, out_id, out_underflow} !==
            {1'b1, 11'd0, 5'd4, 2'd1, 1'b0}) begin
            failures++;
            $display("FAIL zero_pass: got v=%b m=%b e=%0d id=%0d uf=%b expected 1 0 4 1 0",
                     out_valid, out_mantissa, out_exponent, out_id, out_underflow);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        int ids[$];
        do_reset();
        for (int i = 0; i < N; i++) begin
            mant[i] = M'(i + 1);
            expo[i] = 5'd31;
        end
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if (req_ready !== (4'b0001 << (c % N))) begin
                    failures++;
                    $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready,
                             4'b0001 << (c % N));
                end
            end
            if (out_valid) ids.push_back(int'(out_id));
            @(posedge clk);
            #1;
        end
        checks++;
        if (ids.size() != 8) begin
            failures++;
            $display("FAIL rr_count: got %0d expected 8", ids.size());
        end
        for (int k = 0; k < ids.size() && k < 8; k++) begin
            checks++;
            if (ids[k] != k % N) begin
                failures++;
                $display("FAIL rr_id[%0d]: got %0d expected %0d", k, ids[k], k % N);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [M-1:0] sent[$];
        logic [M-1:0] got[$];
        logic [M-1:0] snap_m;
        logic [E-1:0] snap_e;
        logic [IW-1:0] snap_id;
        int nsent = 0;
        do_reset();
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            req_valid = (nsent < 6) ? 4'b1000 : 4'b0000;
            mant[3]   = M'(11'h100 + nsent);
            expo[3]   = 5'd20;
            out_ready = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                checks++;
                if (req_ready !== 4'b0000 || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_stall[%0d]: got ready=%b v=%b expected 0000 1", c,
                             req_ready, out_valid);
                end
                if (c == 2) begin
                    snap_m  = out_mantissa;
                    snap_e  = out_exponent;
                    snap_id = out_id;
                end else begin
                    checks++;
                    if ({out_mantissa, out_exponent, out_id} !== {snap_m, snap_e, snap_id}) begin
                        failures++;
                        $display("FAIL bp_hold[%0d]: got %h/%h/%h expected %h/%h/%h", c,
                                 out_mantissa, out_exponent, out_id, snap_m, snap_e, snap_id);
                    end
                end
            end
            if (req_valid[3] && req_ready[3]) begin
                sent.push_back(mant[3]);
                nsent++;
            end
            if (out_valid && out_ready) got.push_back(out_mantissa);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        out_ready = 1'b1;
        checks++;
        if (got.size() != 6 || sent.size() != 6) begin
            failures++;
            $display("FAIL bp_count: got out=%0d sent=%0d expected 6 6", got.size(), sent.size());
        end
        for (int k = 0; k < got.size() && k < sent.size(); k++) begin
            checks++;
            if (got[k] !== ref_norm(sent[k], ref_shift(sent[k]))) begin
                failures++;
                $display("FAIL bp_order[%0d]: got %h expected %h", k, got[k],
                         ref_norm(sent[k], ref_shift(sent[k])));
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b0;
        mant[0] = 11'h055;
        expo[0] = 5'd9;
        req_valid = 4'b0001;
        @(posedge clk);
        #1;
        mant[1] = 11'h123;
        expo[1] = 5'd9;
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || norm_in_mantissa !== 11'h123) begin
            failures++;
            $display("FAIL mid_fill: got v=%b nin=%h expected 1 123", out_valid, norm_in_mantissa);
        end
        rst       = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL mid_rst_ready: got %b expected 0000", req_ready);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 4'b0110;
        mant[1]   = 11'h2AA;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0010 || norm_in_mantissa !== 11'd0) begin
            failures++;
            $display("FAIL mid_after: got v=%b ready=%b nin=%h expected 0 0010 000",
                     out_valid, req_ready, norm_in_mantissa);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (norm_in_mantissa !== 11'h2AA) begin
            failures++;
            $display("FAIL mid_regrant: got %h expected 2aa", norm_in_mantissa);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        // Reference state: pending operand, held result, pointer.
        bit m_s1v, m_ov;
        logic [M-1:0] m_s1m, m_om;
        logic [E-1:0] m_s1e, m_oe;
        int m_s1id, m_oid, m_rr;
        bit m_ouf;
        bit any, found, s2l, s1l, acc;
        int g, s;
        logic [N-1:0] exp_ready;
        logic signed [M-1:0] t;
        do_reset();
        m_s1v = 0; m_ov = 0; m_rr = 0; m_s1id = 0; m_oid = 0; m_ouf = 0;
        m_s1m = '0; m_s1e = '0; m_om = '0; m_oe = '0;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            req_valid = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                t       = M'($urandom);
                t       = t >>> $urandom_range(0, M - 1);
                mant[i] = t;
                expo[i] = E'($urandom);
            end
            @(negedge clk);
            any   = (req_valid != 0);
            found = 0;
            g     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[(m_rr + k) % N]) begin
                    found = 1;
                    g     = (m_rr + k) % N;
                end
            end
            s2l = m_s1v && (!m_ov || out_ready);
            s1l = !m_s1v || s2l;
            acc = any && s1l && !rst;
            exp_ready = acc ? (4'b0001 << g) : 4'b0000;
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, exp_ready);
            end
            checks++;
            if (out_valid !== m_ov || norm_in_mantissa !== (m_s1v ? m_s1m : 11'd0)) begin
                failures++;
                $display("FAIL rand_state[%0d]: got v=%b nin=%h expected %b %h", c, out_valid,
                         norm_in_mantissa, m_ov, m_s1v ? m_s1m : 11'd0);
            end
            if (m_ov) begin
                checks++;
                if ({out_mantissa, out_exponent, out_id, out_underflow} !==
                    {m_om, m_oe, IW'(m_oid), m_ouf}) begin
                    failures++;
                    $display("FAIL rand_out[%0d]: got %h/%0d/%0d/%b expected %h/%0d/%0d/%b", c,
                             out_mantissa, out_exponent, out_id, out_underflow,
                             m_om, m_oe, m_oid, m_ouf);
                end
            end
            if (rst) begin
                m_s1v = 0; m_ov = 0; m_rr = 0;
                m_om = '0; m_oe = '0; m_oid = 0; m_ouf = 0;
            end else begin
                if (s2l) begin
                    s = ref_shift(m_s1m);
                    if (s <= int'(m_s1e)) begin
                        m_om = ref_norm(m_s1m, s); m_oe = m_s1e - E'(s); m_ouf = 0;
                    end else begin
                        m_om = '0; m_oe = '0; m_ouf = 1;
                    end
                    m_oid = m_s1id;
                    m_ov  = 1;
                end else if (m_ov && out_ready) begin
                    m_ov = 0;
                end
                if (acc) begin
                    m_s1v = 1; m_s1m = mant[g]; m_s1e = expo[g]; m_s1id = g;
                    m_rr  = (g + 1) % N;
                end else if (s2l) begin
                    m_s1v = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            mant[i] = '0;
            expo[i] = '0;
        end
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
